input_event_replayer: RTL and testbench

Synthesizable upstream stimulus stage for the generated RTLola monitor (`topEntity`). The block holds a small table of timed input events, each a gap and a value. On command it replays them as one-cycle `new_input_0` pulses carrying `input_0`, with cycle-exact spacing. It replaces hand-written `#delay` stimulus, so the same event traces run on FPGA and in simulation, and it connects port-for-port to the monitor's `input_0`/`new_input_0` pair.

---
 rtl/replay_pkg.sv | 22 ++
 rtl/input_event_replayer_event_table.sv | 39 +++
 rtl/input_event_replayer.sv | 201 ++++++++++++++++++++
 tb/tb_input_event_replayer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/replay_pkg.sv
// Shared types and default sizes for the input event replayer.
package replay_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int GAP_W_DEF  = 32;
  localparam int DEPTH_DEF  = 16;

  // Replay sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIRE = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // One timed event: idle cycles before it, then the value it carries.
  typedef struct packed {
    logic        [GAP_W_DEF-1:0]  gap;
    logic signed [DATA_W_DEF-1:0] value;
  } event_t;

endpackage

// File: rtl/input_event_replayer_event_table.sv
// Event table: DEPTH entries of {gap, value}, synchronous write, two
// combinational read ports (current event and the one after it).
module event_table
  import replay_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int GAP_W  = GAP_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic        [AW-1:0]     waddr_i,
  input  logic        [GAP_W-1:0]  wgap_i,
  input  logic signed [DATA_W-1:0] wvalue_i,
  input  logic        [AW-1:0]     raddr_cur_i,
  input  logic        [AW-1:0]     raddr_nxt_i,
  output logic        [GAP_W-1:0]  gap_cur_o,
  output logic signed [DATA_W-1:0] value_cur_o,
  output logic        [GAP_W-1:0]  gap_nxt_o
);

  logic        [GAP_W-1:0]  gap_q   [DEPTH];
  logic signed [DATA_W-1:0] value_q [DEPTH];

  // Table storage: updated only on a write strobe and intentionally not reset,
  // so a loaded trace survives a reset of the sequencer.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      gap_q[waddr_i]   <= wgap_i;
      value_q[waddr_i] <= wvalue_i;
    end
  end

  assign gap_cur_o   = gap_q[raddr_cur_i];
  assign value_cur_o = value_q[raddr_cur_i];
  assign gap_nxt_o   = gap_q[raddr_nxt_i];

endmodule

// File: rtl/input_event_replayer.sv
// Replays a table of timed events as one-cycle new_input_0 pulses.
// Each event costs gap+1 WAIT cycles plus one FIRE cycle, so pulses are
// never adjacent. All outputs are registered; en freezes everything.
module input_event_replayer
  import replay_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int GAP_W  = GAP_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     load_we,
  input  logic        [AW-1:0]     load_addr,
  input  logic        [GAP_W-1:0]  load_gap,
  input  logic signed [DATA_W-1:0] load_value,
  input  logic        [LW-1:0]     cfg_len,
  input  logic                     start,
  input  logic                     stop,
  output logic signed [DATA_W-1:0] input_0,
  output logic                     new_input_0,
  output logic                     busy,
  output logic                     done,
  output logic        [AW-1:0]     evt_idx
);

  localparam logic [LW-1:0] DEPTH_LEN = LW'(DEPTH);

  state_e                    state_q, state_d;
  logic        [GAP_W-1:0]   cnt_q,   cnt_d;
  logic        [AW-1:0]      idx_q,   idx_d;
  logic        [LW-1:0]      len_q,   len_d;
  logic signed [DATA_W-1:0]  in0_q,   in0_d;
  logic                      new_q,   new_d;
  logic                      busy_q,  busy_d;
  logic                      done_q,  done_d;

  logic                      tbl_we_s;
  logic                      len_ok_s;
  logic                      last_s;
  logic                      cnt_zero_s;
  logic        [AW-1:0]      rd_cur_s;
  logic        [AW-1:0]      rd_nxt_s;
  logic        [GAP_W-1:0]   gap_cur_s;
  logic        [GAP_W-1:0]   gap_nxt_s;
  logic signed [DATA_W-1:0]  value_cur_s;

  // The table is writable only while idle, so a running trace cannot change.
  assign tbl_we_s   = en && load_we && (state_q == ST_IDLE);
  assign len_ok_s   = (cfg_len != '0) && (cfg_len <= DEPTH_LEN);
  assign last_s     = ({1'b0, idx_q} == (len_q - LW'(1)));
  assign cnt_zero_s = (cnt_q == '0);
  // While idle the current port points at entry 0 so start can load gap[0].
  assign rd_cur_s   = (state_q == ST_IDLE) ? '0 : idx_q;
  assign rd_nxt_s   = idx_q + AW'(1);

  event_table #(
    .DATA_W (DATA_W),
    .GAP_W  (GAP_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_table (
    .clk_i       (clk),
    .we_i        (tbl_we_s),
    .waddr_i     (load_addr),
    .wgap_i      (load_gap),
    .wvalue_i    (load_value),
    .raddr_cur_i (rd_cur_s),
    .raddr_nxt_i (rd_nxt_s),
    .gap_cur_o   (gap_cur_s),
    .value_cur_o (value_cur_s),
    .gap_nxt_o   (gap_nxt_s)
  );

  // State and output registers; async reset, everything held while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      in0_q   <= '0;
      new_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      in0_q   <= in0_d;
      new_q   <= new_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; stop overrides every other transition while busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_ok_s) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (cnt_zero_s) begin
          state_d = ST_FIRE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_FIRE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and next output values; pulses and value default to zero.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    len_d  = len_q;
    in0_d  = '0;
    new_d  = 1'b0;
    busy_d = (state_d == ST_WAIT) || (state_d == ST_FIRE);
    done_d = (state_d == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (start && len_ok_s) begin
          len_d = cfg_len;
          idx_d = '0;
          cnt_d = gap_cur_s;
        end else begin
          len_d = len_q;
        end
      end
      ST_WAIT: begin
        if (stop) begin
          cnt_d = '0;
          idx_d = '0;
        end else if (cnt_zero_s) begin
          in0_d = value_cur_s;
          new_d = 1'b1;
        end else begin
          // Only decremented when non-zero, so a full-scale gap never wraps.
          cnt_d = cnt_q - GAP_W'(1);
        end
      end
      ST_FIRE: begin
        if (stop) begin
          cnt_d = '0;
          idx_d = '0;
        end else if (last_s) begin
          idx_d = idx_q;
        end else begin
          idx_d = idx_q + AW'(1);
          cnt_d = gap_nxt_s;
        end
      end
      ST_DONE: begin
        idx_d = idx_q;
      end
      default: begin
        cnt_d = '0;
        idx_d = '0;
      end
    endcase
  end

  assign input_0     = in0_q;
  assign new_input_0 = new_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign evt_idx     = idx_q;

endmodule

// File: tb/tb_input_event_replayer.sv
// Directed self-checking bench for input_event_replayer.
module tb_input_event_replayer;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               load_we;
  logic        [3:0]  load_addr;
  logic        [31:0] load_gap;
  logic signed [63:0] load_value;
  logic        [4:0]  cfg_len;
  logic               start;
  logic               stop;
  logic signed [63:0] input_0;
  logic               new_input_0;
  logic               busy;
  logic               done;
  logic        [3:0]  evt_idx;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int                 p_cyc[$];
  logic signed [63:0] p_val[$];
  int                 d_cyc[$];
  int                 bad_zero  = 0;
  int                 busy_seen = 0;

  input_event_replayer dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_gap    (load_gap),
    .load_value  (load_value),
    .cfg_len     (cfg_len),
    .start       (start),
    .stop        (stop),
    .input_0     (input_0),
    .new_input_0 (new_input_0),
    .busy        (busy),
    .done        (done),
    .evt_idx     (evt_idx)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge e (and until the next edge), cyc == e.
  always @(posedge clk) cyc <= cyc + 1;

  // Records pulses, done pulses and stray values on the falling edge.
  always @(negedge clk) begin
    if (new_input_0) begin
      p_cyc.push_back(cyc);
      p_val.push_back(input_0);
    end else if (input_0 != 64'sd0) begin
      bad_zero++;
    end
    if (done) d_cyc.push_back(cyc);
    if (busy) busy_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    p_cyc.delete();
    p_val.delete();
    d_cyc.delete();
    bad_zero  = 0;
    busy_seen = 0;
  endtask

  task automatic load_entry(input int a, input logic [31:0] g, input logic signed [63:0] v);
    load_addr  = a[3:0];
    load_gap   = g;
    load_value = v;
    load_we    = 1'b1;
    tick();
    load_we    = 1'b0;
  endtask

  // Start is sampled at edge t, which is returned.
  task automatic do_start(input int len, output int t);
    cfg_len = len[4:0];
    start   = 1'b1;
    t       = cyc + 1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (d_cyc.size() != 0) break;
      tick();
    end
    n_tests++;
    if (d_cyc.size() == 0) begin
      n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles (got 0 done pulses, required 1)", name, budget);
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load_we = 1'b0; load_addr = 4'd0; load_gap = 32'd0;
    load_value = 64'sd0; cfg_len = 5'd0; start = 1'b0; stop = 1'b0;
    #2;
    n_tests++;
    if ({new_input_0, busy, done} !== 3'b000 || input_0 !== 64'sd0 || evt_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got new=%b busy=%b done=%b in=%0d idx=%0d, required all 0",
               new_input_0, busy, done, input_0, evt_idx);
    end
    tick(); tick();
    @(negedge clk); rst = 1'b0;
    tick(); tick();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || new_input_0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b new=%b, required 0 0 0", busy, done, new_input_0);
    end
  endtask

  task automatic test_single();
    int t;
    load_entry(0, 32'd3, 64'sd1);
    clear_rec();
    do_start(1, t);
    wait_done(50, "single");
    n_tests++;
    if (p_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d pulses, required 1", p_cyc.size());
    end else begin
      n_tests++;
      if (p_cyc[0] != t + 4 || p_val[0] !== 64'sd1) begin
        n_fail++;
        $display("FAIL single_pulse: got edge t+%0d value %0d, required t+4 value 1", p_cyc[0] - t, p_val[0]);
      end
    end
    n_tests++;
    if (d_cyc.size() != 1 || d_cyc[0] != t + 5) begin
      n_fail++;
      $display("FAIL single_done: got %0d done pulses (first t+%0d), required 1 at t+5",
               d_cyc.size(), (d_cyc.size() > 0) ? d_cyc[0] - t : -1);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_after: got %b, required 0", busy);
    end
  endtask

  task automatic test_trace();
    int t;
    int exp_c[3];
    logic signed [63:0] exp_v[3];
    load_entry(0, 32'd5, 64'sd2);
    load_entry(1, 32'd0, -64'sd3);
    load_entry(2, 32'd2, 64'sd9);
    clear_rec();
    do_start(3, t);
    // gap+1 WAIT cycles and one FIRE per event
    exp_c[0] = t + 6;  exp_c[1] = t + 8;  exp_c[2] = t + 12;
    exp_v[0] = 64'sd2; exp_v[1] = -64'sd3; exp_v[2] = 64'sd9;
    wait_done(80, "trace");
    n_tests++;
    if (p_cyc.size() != 3) begin
      n_fail++;
      $display("FAIL trace_count: got %0d pulses, required 3", p_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (p_cyc[k] != exp_c[k] || p_val[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL trace_ev%0d: got edge t+%0d value %0d, required t+%0d value %0d",
                   k, p_cyc[k] - t, p_val[k], exp_c[k] - t, exp_v[k]);
        end
      end
    end
    n_tests++;
    if (bad_zero != 0 || d_cyc.size() != 1 || d_cyc[0] != t + 13) begin
      n_fail++;
      $display("FAIL trace_done_zero: got stray=%0d done_count=%0d, required stray=0 one done at t+13",
               bad_zero, d_cyc.size());
    end
  endtask

  task automatic test_stop();
    int t;
    load_entry(0, 32'd4, 64'sd10);
    load_entry(1, 32'd4, 64'sd11);
    load_entry(2, 32'd4, 64'sd12);
    clear_rec();
    do_start(3, t);
    for (int i = 0; i < 7; i++) tick();
    n_tests++;
    if (busy !== 1'b1 || evt_idx !== 4'd1) begin
      n_fail++;
      $display("FAIL stop_pre: got busy=%b idx=%0d, required busy=1 idx=1", busy, evt_idx);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || evt_idx !== 4'd0 || new_input_0 !== 1'b0 || input_0 !== 64'sd0) begin
      n_fail++;
      $display("FAIL stop_clear: got busy=%b idx=%0d new=%b in=%0d, required all 0",
               busy, evt_idx, new_input_0, input_0);
    end
    for (int i = 0; i < 30; i++) tick();
    n_tests++;
    if (p_cyc.size() != 1 || d_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL stop_quiet: got %0d pulses %0d done, required 1 pulses 0 done", p_cyc.size(), d_cyc.size());
    end
    clear_rec();
    do_start(3, t);
    wait_done(80, "stop_restart");
    n_tests++;
    if (p_cyc.size() != 3) begin
      n_fail++;
      $display("FAIL stop_restart_count: got %0d pulses, required 3", p_cyc.size());
    end else begin
      n_tests++;
      if (p_cyc[0] != t + 5 || p_val[0] !== 64'sd10 || p_cyc[2] != t + 17 || p_val[2] !== 64'sd12) begin
        n_fail++;
        $display("FAIL stop_restart: got t+%0d=%0d t+%0d=%0d, required t+5=10 t+17=12",
                 p_cyc[0] - t, p_val[0], p_cyc[2] - t, p_val[2]);
      end
    end
  endtask

  task automatic test_enable();
    int t;
    int frozen_bad;
    load_entry(0, 32'd2, 64'sd7);
    load_entry(1, 32'd1, 64'sd8);
    clear_rec();
    do_start(2, t);
    tick(); tick(); tick();
    n_tests++;
    if (new_input_0 !== 1'b1 || input_0 !== 64'sd7) begin
      n_fail++;
      $display("FAIL en_first: got new=%b in=%0d, required 1 7", new_input_0, input_0);
    end
    en = 1'b0;
    frozen_bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (new_input_0 !== 1'b1 || input_0 !== 64'sd7) frozen_bad++;
    end
    en = 1'b1;
    n_tests++;
    if (frozen_bad != 0) begin
      n_fail++;
      $display("FAIL en_frozen: got %0d cycles with dropped pulse, required 0", frozen_bad);
    end
    wait_done(50, "en");
    n_tests++;
    if (p_cyc.size() != 7) begin
      n_fail++;
      $display("FAIL en_count: got %0d pulse samples, required 7", p_cyc.size());
    end else begin
      n_tests++;
      if (p_cyc[6] != t + 11 || p_val[6] !== 64'sd8 || d_cyc[0] != t + 12) begin
        n_fail++;
        $display("FAIL en_shift: got pulse t+%0d value %0d done t+%0d, required t+11 8 t+12",
                 p_cyc[6] - t, p_val[6], d_cyc[0] - t);
      end
    end
  endtask

  task automatic test_len_bounds();
    int t;
    int exp_c[16];
    logic signed [63:0] exp_v[16];
    int bad_lens[2];
    bad_lens[0] = 0;
    bad_lens[1] = 17;
    for (int j = 0; j < 2; j++) begin
      clear_rec();
      do_start(bad_lens[j], t);
      tick(); tick(); tick();
      n_tests++;
      if (d_cyc.size() != 1 || d_cyc[0] != t || p_cyc.size() != 0 || busy_seen != 0) begin
        n_fail++;
        $display("FAIL len%0d: got done_count=%0d pulses=%0d busy_cycles=%0d, required 1 done at t, 0, 0",
                 bad_lens[j], d_cyc.size(), p_cyc.size(), busy_seen);
      end
    end
    for (int k = 0; k < 16; k++) begin
      exp_v[k] = 64'(k * 100) - 64'sd500;
      load_entry(k, 32'(k % 2), exp_v[k]);
    end
    clear_rec();
    do_start(16, t);
    exp_c[0] = t + 1 + 0;
    for (int k = 1; k < 16; k++) exp_c[k] = exp_c[k-1] + 2 + (k % 2);
    wait_done(200, "len16");
    n_tests++;
    if (p_cyc.size() != 16) begin
      n_fail++;
      $display("FAIL len16_count: got %0d pulses, required 16", p_cyc.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        n_tests++;
        if (p_cyc[k] != exp_c[k] || p_val[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL len16_ev%0d: got edge t+%0d value %0d, required t+%0d value %0d",
                   k, p_cyc[k] - t, p_val[k], exp_c[k] - t, exp_v[k]);
        end
      end
    end
    n_tests++;
    if (evt_idx !== 4'd15 || d_cyc.size() != 1 || d_cyc[0] != exp_c[15] + 1) begin
      n_fail++;
      $display("FAIL len16_end: got idx=%0d done_count=%0d, required idx=15 one done after last pulse",
               evt_idx, d_cyc.size());
    end
  endtask

  task automatic test_async_reset();
    int t;
    clear_rec();
    do_start(16, t);
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (busy !== 1'b1 || evt_idx !== 4'd2) begin
      n_fail++;
      $display("FAIL rst_pre: got busy=%b idx=%0d, required 1 2", busy, evt_idx);
    end
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if ({new_input_0, busy, done} !== 3'b000 || input_0 !== 64'sd0 || evt_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_async: got new=%b busy=%b done=%b in=%0d idx=%0d, required all 0",
               new_input_0, busy, done, input_0, evt_idx);
    end
    #2 rst = 1'b0;
    tick();
    clear_rec();
    do_start(3, t);
    wait_done(60, "rst_replay");
    n_tests++;
    if (p_cyc.size() != 3) begin
      n_fail++;
      $display("FAIL rst_replay_count: got %0d pulses, required 3", p_cyc.size());
    end else begin
      n_tests++;
      if (p_val[0] !== -64'sd500 || p_val[1] !== -64'sd400 || p_val[2] !== -64'sd300 ||
          p_cyc[0] != t + 1 || p_cyc[1] != t + 4 || p_cyc[2] != t + 6) begin
        n_fail++;
        $display("FAIL rst_replay: got %0d@t+%0d %0d@t+%0d %0d@t+%0d, required -500@t+1 -400@t+4 -300@t+6",
                 p_val[0], p_cyc[0] - t, p_val[1], p_cyc[1] - t, p_val[2], p_cyc[2] - t);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_trace();
    test_stop();
    test_enable();
    test_len_bounds();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
